alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
// - Tomasulo reservation station bank for the ALU units: accepts dispatched ops, snoops the CDB for missing operands.
// - Issues the oldest ready op to its ALU; the ALU result goes to the completion queue, which broadcasts on the CDB.
// - Sits between dispatch/rename (upstream), the ALU (downstream) and the CDB (snoop input).
// PARAMETERS
// - NUM_ENTRIES  4  number of RS entries (power of 2, 2..8)
// - TAG_BASE     1  RS_tag_type value of entry 0; entry i owns tag TAG_BASE+i (never INVALID)
// PORTS
// - CLK          in   1            clock, all state on posedge
// - RST          in   1            synchronous, active-high reset
// - FLUSH        in   1            sync clear of all entries (mispredict)
// - DISP_VALID   in   1            dispatch request
// - DISP_READY   out  1            at least one free entry
// - DISP_TAG     out  RS_tag_type  tag of the entry that will be allocated (valid when DISP_READY)
// - DISP_FUN     in   4            ALU function code
// - DISP_VJ      in   32           operand A value (used when DISP_QJ==INVALID)
// - DISP_QJ      in   RS_tag_type  producer tag of A, INVALID = value ready
// - DISP_VK      in   32           operand B value
// - DISP_QK      in   RS_tag_type  producer tag of B
// - CDB_IN       in   cdb_t        {tag, data} broadcast; tag INVALID = idle
// - ISSUE_VALID  out  1            selected entry ready
// - ISSUE_READY  in   1            ALU accepts this cycle
// - ISSUE_FUN    out  4            function of selected entry
// - ISSUE_A      out  32           operand A
// - ISSUE_B      out  32           operand B
// - ISSUE_TAG    out  RS_tag_type  tag of selected entry (forwarded by ALU to the completion queue)
// BEHAVIOUR
// - Entry state: busy, fun, vj, qj, vk, qk, age[$clog2(NUM_ENTRIES)-1:0].
// - Reset/FLUSH: all busy=0, age=0 next cycle; DISP_READY=1, ISSUE_VALID=0; dispatch and issue are ignored that cycle.
// - DISP_READY = |~busy, from registered state only. DISP_TAG = TAG_BASE + lowest free index.
// - Dispatch fires on posedge when DISP_VALID & DISP_READY. Lowest free entry gets busy=1, age=0.
// - Every other busy entry increments its age on dispatch.
// - Dispatch bypass: if DISP_QJ==CDB_IN.tag!=INVALID, store vj=CDB_IN.data, qj=INVALID. Same rule for K.
// - Snoop: each busy entry with qj==CDB_IN.tag!=INVALID captures data and sets qj=INVALID. Same for K; both may match.
// - ready[i] = busy & qj==INVALID & qk==INVALID, from registered state only.
// - No CDB-to-issue combinational bypass: one-cycle wakeup.
// - Select: among ready entries, pick the highest age (oldest); ages are unique among busy entries.
// - ISSUE_VALID = |ready. ISSUE_* come from the selected entry, and are all 0 when !ISSUE_VALID.
// - Issue fires on posedge when ISSUE_VALID & ISSUE_READY: that entry sets busy=0.
// - Busy entries with age > issued age decrement.
// - ISSUE_* must remain stable while ISSUE_VALID & !ISSUE_READY, unless an older entry becomes ready.
// - Simultaneous dispatch+issue: apply the issue decrement first, then the dispatch increment, so ages stay in 0..busy_count-1.
// - Entry freed by issue is not visible to DISP_READY until the next cycle. Full bank with issue the same cycle -> DISP_READY=0 this cycle.
// - Latency: dispatch with both operands ready -> ISSUE_VALID the following cycle.
// - Waiting operand: CDB match at edge N -> ISSUE_VALID in cycle N+1.
// - DISP_VALID while !DISP_READY: no state change; the upstream holds the request.
// STRUCTURE
// - cpu_types package additions: rs_entry_t struct {busy, fun, vj, qj, vk, qk, age}.
// - cpu_types also holds the ALU function-code width constant. RS_tag_type, INVALID and cdb_t are reused from cpu_types.
// - Sub-module rs_age_select: combinational; ready vector + ages in -> one-hot grant, index, valid out.
// - Entry array, dispatch allocation, snoop and age update stay in this module.
// TESTING
// - Reset then dispatch {FUN=0,VJ=5,QJ=INVALID,VK=7,QK=INVALID}, ISSUE_READY=1
//   -> DISP_TAG=TAG_BASE; next cycle ISSUE_VALID=1, A=5, B=7, TAG=TAG_BASE; entry freed after.
// - Dispatch with QJ=T9 waiting; 3 cycles later CDB_IN={T9,32'hDEAD}
//   -> ISSUE_VALID=0 until the edge after the CDB, then ISSUE_A=32'hDEAD.
// - Dispatch QJ=T9 while CDB_IN={T9,32'h1234} the same cycle -> entry captures 32'h1234 and issues the next cycle.
// - Fill 4 entries with ISSUE_READY=0 -> DISP_READY=0; DISP_VALID held causes no write.
//   Then ISSUE_READY=1 -> issue in dispatch order TAG_BASE..TAG_BASE+3.
// - Entries 0 (older, waiting) and 1 (ready): 1 issues first; when 0 wakes it issues.
//   Dispatch into the freed entry 1 -> new op issues after entry 0.
// - FLUSH with 3 busy entries plus a concurrent DISP_VALID
//   -> next cycle DISP_READY=1, ISSUE_VALID=0, DISP_TAG=TAG_BASE; the dispatch is dropped.

Source files
------------

// File: rtl/cpu_types.sv
// Shared CPU types: rename tags, CDB broadcast format, reservation-station entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types;

  localparam int TAG_W    = 4;
  localparam int FUN_W    = 4;
  // Wide enough for the largest supported bank (8 entries).
  localparam int RS_AGE_W = 3;

  typedef logic [TAG_W-1:0] RS_tag_type;

  // Tag value meaning "no producer" / "CDB idle".
  localparam RS_tag_type INVALID = '0;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

  typedef struct packed {
    logic                busy;
    logic [FUN_W-1:0]    fun;
    logic [31:0]         vj;
    RS_tag_type          qj;
    logic [31:0]         vk;
    RS_tag_type          qk;
    logic [RS_AGE_W-1:0] age;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry with the highest age.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rs_age_select
  import cpu_types::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]                ready,
  input  logic [N-1:0][RS_AGE_W-1:0]  ages,
  output logic [N-1:0]                grant,
  output logic [IW-1:0]               idx,
  output logic                        vld
);

  logic [RS_AGE_W-1:0] best_age;

  // Linear scan keeping the oldest ready entry; ages are unique among busy entries.
  always_comb begin
    grant    = '0;
    idx      = '0;
    vld      = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!vld || ages[i] > best_age)) begin
        vld      = 1'b1;
        best_age = ages[i];
        idx      = IW'(i);
      end
    end
    grant[idx] = vld;
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station bank: holds dispatched ops, snoops CDB, issues oldest ready op.
// Latency: ready-at-dispatch op issues next cycle; CDB wakeup at edge N issues in cycle N+1.
// Backpressure: DISP_READY low when full (upstream holds); ISSUE_* held stable until ISSUE_READY.
module alu_reservation_station
  import cpu_types::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_BASE    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             DISP_VALID,
  output logic             DISP_READY,
  output RS_tag_type       DISP_TAG,
  input  logic [FUN_W-1:0] DISP_FUN,
  input  logic [31:0]      DISP_VJ,
  input  RS_tag_type       DISP_QJ,
  input  logic [31:0]      DISP_VK,
  input  RS_tag_type       DISP_QK,
  input  cdb_t             CDB_IN,
  output logic             ISSUE_VALID,
  input  logic             ISSUE_READY,
  output logic [FUN_W-1:0] ISSUE_FUN,
  output logic [31:0]      ISSUE_A,
  output logic [31:0]      ISSUE_B,
  output RS_tag_type       ISSUE_TAG
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  rs_entry_t entry_q [NUM_ENTRIES];
  rs_entry_t entry_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]               busy;
  logic [NUM_ENTRIES-1:0]               ready;
  logic [NUM_ENTRIES-1:0]               grant;
  logic [NUM_ENTRIES-1:0]               alloc;
  logic [NUM_ENTRIES-1:0][RS_AGE_W-1:0] ages;
  logic [IW-1:0]                        free_idx;
  logic [IW-1:0]                        sel_idx;
  logic                                 sel_vld;
  logic [RS_AGE_W-1:0]                  sel_age;
  logic                                 disp_fire;
  logic                                 issue_fire;
  logic                                 cdb_vld;

  // Status vectors derived only from registered entry state.
  always_comb begin
    busy  = '0;
    ready = '0;
    ages  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy[i]  = entry_q[i].busy;
      ready[i] = entry_q[i].busy && (entry_q[i].qj == INVALID) && (entry_q[i].qk == INVALID);
      ages[i]  = entry_q[i].age;
    end
  end

  // Lowest-index free entry is the allocation target.
  always_comb begin
    free_idx = '0;
    alloc    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
    end
    alloc[free_idx] = |(~busy);
  end

  rs_age_select #(
    .N  (NUM_ENTRIES),
    .IW (IW)
  ) u_select (
    .ready (ready),
    .ages  (ages),
    .grant (grant),
    .idx   (sel_idx),
    .vld   (sel_vld)
  );

  assign DISP_READY = |(~busy);
  assign DISP_TAG   = RS_tag_type'(TAG_BASE + int'(free_idx));
  assign sel_age    = entry_q[sel_idx].age;
  assign disp_fire  = DISP_VALID && DISP_READY && !FLUSH;
  assign issue_fire = sel_vld && ISSUE_READY && !FLUSH;
  assign cdb_vld    = (CDB_IN.tag != INVALID);

  // Issue port driven from the selected entry, zeroed when nothing is ready.
  always_comb begin
    ISSUE_VALID = sel_vld;
    ISSUE_FUN   = '0;
    ISSUE_A     = '0;
    ISSUE_B     = '0;
    ISSUE_TAG   = INVALID;
    if (sel_vld) begin
      ISSUE_FUN = entry_q[sel_idx].fun;
      ISSUE_A   = entry_q[sel_idx].vj;
      ISSUE_B   = entry_q[sel_idx].vk;
      ISSUE_TAG = RS_tag_type'(TAG_BASE + int'(sel_idx));
    end
  end

  // Per-entry next state: snoop, issue release, age update (issue before dispatch), allocation.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (FLUSH) begin
        entry_d[i] = '0;
      end else if (entry_q[i].busy) begin
        if (cdb_vld && entry_q[i].qj == CDB_IN.tag) begin
          entry_d[i].vj = CDB_IN.data;
          entry_d[i].qj = INVALID;
        end
        if (cdb_vld && entry_q[i].qk == CDB_IN.tag) begin
          entry_d[i].vk = CDB_IN.data;
          entry_d[i].qk = INVALID;
        end
        if (issue_fire && grant[i]) begin
          entry_d[i].busy = 1'b0;
          entry_d[i].age  = '0;
        end else begin
          if (issue_fire && entry_q[i].age > sel_age) entry_d[i].age = entry_d[i].age - 1'b1;
          if (disp_fire) entry_d[i].age = entry_d[i].age + 1'b1;
        end
      end else if (disp_fire && alloc[i]) begin
        entry_d[i].busy = 1'b1;
        entry_d[i].fun  = DISP_FUN;
        entry_d[i].age  = '0;
        entry_d[i].vj   = DISP_VJ;
        entry_d[i].qj   = DISP_QJ;
        entry_d[i].vk   = DISP_VK;
        entry_d[i].qk   = DISP_QK;
        // Producer broadcasting in the dispatch cycle would otherwise be missed.
        if (DISP_QJ != INVALID && DISP_QJ == CDB_IN.tag) begin
          entry_d[i].vj = CDB_IN.data;
          entry_d[i].qj = INVALID;
        end
        if (DISP_QK != INVALID && DISP_QK == CDB_IN.tag) begin
          entry_d[i].vk = CDB_IN.data;
          entry_d[i].qk = INVALID;
        end
      end
    end
  end

  // Entry array register with synchronous reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (RST) entry_q[i] <= '0;
      else     entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpressure: ISSUE_READY toggled by the stimulus to exercise hold and fill.
module tb_alu_reservation_station;
  import cpu_types::*;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, DISP_VALID, DISP_READY, ISSUE_VALID, ISSUE_READY;
  RS_tag_type  DISP_TAG, DISP_QJ, DISP_QK, ISSUE_TAG;
  logic [3:0]  DISP_FUN, ISSUE_FUN;
  logic [31:0] DISP_VJ, DISP_VK, ISSUE_A, ISSUE_B;
  cdb_t        CDB_IN;

  int total = 0;
  int bad   = 0;

  alu_reservation_station #(.NUM_ENTRIES(4), .TAG_BASE(1)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .DISP_VALID(DISP_VALID), .DISP_READY(DISP_READY), .DISP_TAG(DISP_TAG),
    .DISP_FUN(DISP_FUN), .DISP_VJ(DISP_VJ), .DISP_QJ(DISP_QJ),
    .DISP_VK(DISP_VK), .DISP_QK(DISP_QK), .CDB_IN(CDB_IN),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY), .ISSUE_FUN(ISSUE_FUN),
    .ISSUE_A(ISSUE_A), .ISSUE_B(ISSUE_B), .ISSUE_TAG(ISSUE_TAG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    DISP_VALID = 1'b0;
    DISP_FUN   = '0;
    DISP_VJ    = '0;
    DISP_QJ    = INVALID;
    DISP_VK    = '0;
    DISP_QK    = INVALID;
    CDB_IN     = '0;
  endtask

  task automatic disp(input logic [3:0] f, input logic [31:0] vj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic [3:0] qk);
    DISP_VALID = 1'b1;
    DISP_FUN   = f;
    DISP_VJ    = vj;
    DISP_QJ    = qj;
    DISP_VK    = vk;
    DISP_QK    = qk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; FLUSH = 1'b0; ISSUE_READY = 1'b0;
    idle();
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_disp_ready", DISP_READY, 1);
    chk("rst_issue_valid", ISSUE_VALID, 0);
    chk("rst_disp_tag", DISP_TAG, 1);

    // Both operands ready: issues the next cycle.
    ISSUE_READY = 1'b1;
    disp(4'd0, 32'd5, INVALID, 32'd7, INVALID);
    #1;
    chk("simple_disp_tag", DISP_TAG, 1);
    tick(); idle(); #1;
    chk("simple_iv", ISSUE_VALID, 1);
    chk("simple_a", ISSUE_A, 5);
    chk("simple_b", ISSUE_B, 7);
    chk("simple_tag", ISSUE_TAG, 1);
    tick(); #1;
    chk("simple_freed_iv", ISSUE_VALID, 0);
    chk("simple_freed_tag", DISP_TAG, 1);

    // Waiting operand woken by CDB three cycles later.
    disp(4'd3, 32'd0, 4'd9, 32'd2, INVALID);
    tick(); idle(); #1;
    chk("wait_iv0", ISSUE_VALID, 0);
    tick(); #1;
    chk("wait_iv1", ISSUE_VALID, 0);
    tick();
    CDB_IN.tag = 4'd9; CDB_IN.data = 32'hDEAD;
    #1;
    chk("wait_iv_cdb_cycle", ISSUE_VALID, 0);
    tick(); idle(); #1;
    chk("wait_iv_after", ISSUE_VALID, 1);
    chk("wait_a", ISSUE_A, 32'hDEAD);
    chk("wait_b", ISSUE_B, 2);
    chk("wait_fun", ISSUE_FUN, 3);
    chk("wait_tag", ISSUE_TAG, 1);
    tick(); #1;
    chk("wait_done", ISSUE_VALID, 0);

    // Dispatch-time bypass from the CDB.
    disp(4'd4, 32'd0, 4'd9, 32'd1, INVALID);
    CDB_IN.tag = 4'd9; CDB_IN.data = 32'h1234;
    tick(); idle(); #1;
    chk("bypass_iv", ISSUE_VALID, 1);
    chk("bypass_a", ISSUE_A, 32'h1234);
    chk("bypass_b", ISSUE_B, 1);
    tick(); #1;
    chk("bypass_done", ISSUE_VALID, 0);

    // Fill the bank while the ALU stalls.
    ISSUE_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'(i), 32'(10 + i), INVALID, 32'(20 + i), INVALID);
      #1;
      chk("fill_disp_tag", DISP_TAG, 32'(1 + i));
      tick();
    end
    disp(4'd9, 32'd99, INVALID, 32'd98, INVALID);
    #1;
    chk("full_disp_ready", DISP_READY, 0);
    chk("full_issue_tag", ISSUE_TAG, 1);
    chk("full_issue_a", ISSUE_A, 10);
    tick(); #1;
    chk("full_hold_ready", DISP_READY, 0);
    chk("full_hold_a", ISSUE_A, 10);
    idle();
    ISSUE_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 0) chk("full_issue_same_cycle_ready", DISP_READY, 0);
      chk("drain_iv", ISSUE_VALID, 1);
      chk("drain_tag", ISSUE_TAG, 32'(1 + i));
      chk("drain_a", ISSUE_A, 32'(10 + i));
      chk("drain_b", ISSUE_B, 32'(20 + i));
      chk("drain_fun", ISSUE_FUN, 32'(i));
      tick();
    end
    #1;
    chk("drain_empty", ISSUE_VALID, 0);

    // Older waiting entry vs younger ready entry.
    ISSUE_READY = 1'b0;
    disp(4'd1, 32'd0, 4'd9, 32'd4, INVALID);
    tick();
    disp(4'd2, 32'd20, INVALID, 32'd21, INVALID);
    #1;
    chk("age_disp_tag", DISP_TAG, 2);
    tick(); idle(); #1;
    chk("age_young_iv", ISSUE_VALID, 1);
    chk("age_young_tag", ISSUE_TAG, 2);
    chk("age_young_a", ISSUE_A, 20);
    ISSUE_READY = 1'b1;
    tick();
    ISSUE_READY = 1'b0;
    #1;
    chk("age_after_iv", ISSUE_VALID, 0);
    chk("age_reuse_tag", DISP_TAG, 2);
    disp(4'd5, 32'd30, INVALID, 32'd31, INVALID);
    CDB_IN.tag = 4'd9; CDB_IN.data = 32'h77;
    #1;
    chk("age_wake_cycle_iv", ISSUE_VALID, 0);
    tick(); idle(); #1;
    chk("age_old_tag", ISSUE_TAG, 1);
    chk("age_old_a", ISSUE_A, 32'h77);
    chk("age_old_b", ISSUE_B, 4);
    chk("age_old_fun", ISSUE_FUN, 1);
    ISSUE_READY = 1'b1;
    tick(); #1;
    chk("age_new_iv", ISSUE_VALID, 1);
    chk("age_new_tag", ISSUE_TAG, 2);
    chk("age_new_a", ISSUE_A, 30);
    chk("age_new_fun", ISSUE_FUN, 5);
    tick(); #1;
    chk("age_empty", ISSUE_VALID, 0);

    // Flush with three busy entries and a concurrent dispatch.
    ISSUE_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(4'd6, 32'(i), 4'd9, 32'(i), INVALID);
      tick();
    end
    idle();
    FLUSH = 1'b1;
    disp(4'd7, 32'd55, INVALID, 32'd56, INVALID);
    #1;
    chk("flush_pre_tag", DISP_TAG, 4);
    tick();
    FLUSH = 1'b0;
    idle();
    #1;
    chk("flush_disp_ready", DISP_READY, 1);
    chk("flush_iv", ISSUE_VALID, 0);
    chk("flush_disp_tag", DISP_TAG, 1);
    CDB_IN.tag = 4'd9; CDB_IN.data = 32'h1;
    tick(); idle(); #1;
    chk("flush_no_revive", ISSUE_VALID, 0);
    chk("flush_still_empty", DISP_TAG, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
